psram_arbiter: RTL

PSRAM_ARBITER -- requirements
Module: psram_arbiter

---
 rtl/psram_arbiter_pkg.sv | 22 ++
 rtl/psram_arbiter_rr_select.sv | 28 ++
 rtl/psram_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/psram_arbiter_pkg.sv
// Shared types and constants for the PSRAM request arbiter.
package psram_arbiter_pkg;
  localparam int ADDR_W      = 22;
  localparam int DATA_W      = 16;
  localparam int CNT_W       = 5;
  localparam int DEF_TIMEOUT = 31;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic              we;
    logic              byte_we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;
endpackage

// File: rtl/psram_arbiter_rr_select.sv
// Round-robin pick: first requesting port after i_ptr, wrapping modulo N.
module rr_select #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx
);
  logic w_found;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    // k is the distance from the last-served port; nearest requester wins
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < N; j++) begin
        if (!w_found && i_req[j] && (((int'(i_ptr) + 1 + k) % N) == j)) begin
          w_found    = 1'b1;
          o_grant[j] = 1'b1;
          o_idx      = IW'(j);
        end
      end
    end
  end
endmodule

// File: rtl/psram_arbiter.sv
// Arbitrates NPORTS requesters onto one PSRAM controller command port,
// one transaction at a time, with a bounded wait and sticky timeout flag.
module psram_arbiter
  import psram_arbiter_pkg::*;
#(
  parameter int NPORTS  = 2,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NPORTS-1:0]        req,
  input  logic [NPORTS-1:0]        we,
  input  logic [NPORTS-1:0]        byte_we,
  input  logic [NPORTS*ADDR_W-1:0] addr,
  input  logic [NPORTS*DATA_W-1:0] wdata,
  output logic [NPORTS-1:0]        ack,
  output logic [DATA_W-1:0]        rdata,
  output logic                     timeout,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic                     mem_byte_write,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_din,
  input  logic [DATA_W-1:0]        mem_dout,
  input  logic                     mem_busy
);
  localparam int IW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

  state_t              r_state, w_nxt;
  cmd_t                r_cmd;
  logic [IW-1:0]       r_ptr, r_gidx;
  logic [NPORTS-1:0]   r_grant_oh;
  logic [CNT_W-1:0]    r_cnt, w_cnt_inc;
  logic                r_timeout, w_to_hit;
  logic [DATA_W-1:0]   r_rdata;
  cmd_t [NPORTS-1:0]   w_cmd;
  logic [NPORTS-1:0]   w_gnt;
  logic [IW-1:0]       w_idx;

  for (genvar g = 0; g < NPORTS; g++) begin : g_port
    assign w_cmd[g] = '{we:      we[g],
                        byte_we: byte_we[g],
                        addr:    addr[g*ADDR_W +: ADDR_W],
                        wdata:   wdata[g*DATA_W +: DATA_W]};
  end

  rr_select #(.N(NPORTS), .IW(IW)) u_rr (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_grant (w_gnt),
    .o_idx   (w_idx)
  );

  always_comb begin
    w_nxt     = r_state;
    w_to_hit  = 1'b0;
    w_cnt_inc = r_cnt + CNT_W'(1);
    case (r_state)
      ST_INIT:  if (!mem_busy) w_nxt = ST_IDLE;
      ST_IDLE:  if (|req) w_nxt = ST_ISSUE;
      ST_ISSUE: w_nxt = ST_WAIT;
      ST_WAIT: begin
        // r_cnt==0 marks the first WAIT cycle, where busy may not have risen yet
        if (r_cnt != '0) begin
          if (!mem_busy) begin
            w_nxt = ST_DONE;
          end else if (w_cnt_inc == TO_CNT) begin
            w_nxt    = ST_DONE;
            w_to_hit = 1'b1;
          end
        end
      end
      ST_DONE:  w_nxt = ST_IDLE;
      default:  w_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_INIT;
      r_cmd      <= '0;
      r_ptr      <= IW'(NPORTS - 1);
      r_gidx     <= '0;
      r_grant_oh <= '0;
      r_cnt      <= '0;
      r_timeout  <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_state <= w_nxt;
      case (r_state)
        ST_IDLE: if (|req) begin
          r_cmd      <= w_cmd[w_idx];
          r_grant_oh <= w_gnt;
          r_gidx     <= w_idx;
        end
        ST_ISSUE: r_cnt <= '0;
        ST_WAIT: begin
          r_cnt <= w_cnt_inc;
          // capture on the way into DONE so rdata is valid alongside ack
          if (w_nxt == ST_DONE) r_rdata <= mem_dout;
          if (w_to_hit) r_timeout <= 1'b1;
        end
        ST_DONE: r_ptr <= r_gidx;
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_read  = (r_state == ST_ISSUE) && !r_cmd.we;
    mem_write = (r_state == ST_ISSUE) &&  r_cmd.we;
    ack       = (r_state == ST_DONE) ? r_grant_oh : '0;
  end

  assign mem_byte_write = r_cmd.byte_we;
  assign mem_addr       = r_cmd.addr;
  assign mem_din        = r_cmd.wdata;
  assign rdata          = r_rdata;
  assign timeout        = r_timeout;
endmodule
